// File: rtl/player_mover_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : player_mover_pkg
//  Description : Shared definitions for the player-movement path and the
//                collision limiter.
//                - direction encodings (horizontal and vertical axes)
//                - screen and play-field geometry
//                - candidate bounds helper
//  Revision    : 1.0 - initial release
// ============================================================================
package player_mover_pkg;

   // Screen geometry
   localparam int SCREEN_W     = 640;
   localparam int SCREEN_H     = 480;

   // Play field: 8x8 grid of 60-pixel cells starting at x = 80
   localparam int FIELD_X0_DEF = 80;
   localparam int CELL_SIZE    = 60;
   localparam int GRID_N       = 8;
   localparam int FIELD_SIZE   = CELL_SIZE * GRID_N;

   typedef enum logic [1:0] {
      LR_NONE  = 2'd0,
      LR_RIGHT = 2'd1,
      LR_LEFT  = 2'd2
   } lr_dir_e;

   typedef enum logic [1:0] {
      UD_NONE = 2'd0,
      UD_DOWN = 2'd1,
      UD_UP   = 2'd2
   } ud_dir_e;

   // True when a square of size w x h with its top-left corner at (cx, cy)
   // lies completely inside the play field. A y that wrapped below zero
   // shows up as a large unsigned value and fails the upper bound.
   function automatic logic cand_in_field(input logic [9:0] cx,
                                          input logic [9:0] cy,
                                          input int         x0,
                                          input int         w,
                                          input int         h);
      int x;
      int y;
      x = int'(cx);
      y = int'(cy);
      return (x >= x0) && (x <= x0 + FIELD_SIZE - w) && (y <= FIELD_SIZE - h);
   endfunction

endpackage
`default_nettype wire

// File: rtl/player_mover_tick_divider.sv
`default_nettype none
// ============================================================================
//  Module      : player_mover_tick_divider
//  Description : Free-running movement-tick generator. Counts
//                0..MOVE_DIV-1 and wraps; tick is high for the single cycle
//                in which the count equals MOVE_DIV-1.
//  Ports       : clk  - system clock
//                rst  - synchronous reset, active-high (count -> 0)
//                tick - one-cycle movement tick
//  Revision    : 1.0 - initial release
// ============================================================================
module player_mover_tick_divider #(
   parameter int MOVE_DIV = 833333
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int            CW   = (MOVE_DIV > 2) ? $clog2(MOVE_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(MOVE_DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/player_mover.sv
`default_nettype none
// ============================================================================
//  Module      : player_mover
//  Description : Player-position stage. Once per movement tick it decodes the
//                direction buttons into a 1-pixel candidate, bounds-checks
//                it, runs one request/response cycle with the collision
//                limiter and commits or discards the candidate.
//  Option      : PLAYER_MOVE_DIAG_EN - when defined, both axes may move in
//                the same tick (one diagonal limiter request). When not
//                defined, horizontal motion has priority.
//  Ports       : clk, rst               - clock, synchronous active-high reset
//                btn_left/right/up/down - synchronised button levels
//                lim_rst_n, lim_start   - limiter hold/reset and request pulse
//                lim_x_pos, lim_y_pos   - candidate top-left corner
//                lim_width, lim_height  - player square size
//                lim_l_r, lim_u_d       - requested direction per axis
//                lim_done               - limiter finished (sticky)
//                lim_move_is_valid      - limiter verdict, valid with done
//                pos_x, pos_y           - committed player position
//                pos_update             - one-cycle pulse on position change
//                busy                   - high whenever the FSM is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module player_mover
   import player_mover_pkg::*;
#(
   parameter int MOVE_DIV     = 833333,
   parameter int PLAYER_W     = 20,
   parameter int PLAYER_H     = 20,
   parameter int START_X      = 150,
   parameter int START_Y      = 90,
   parameter int FIELD_X0     = FIELD_X0_DEF,
   parameter int DONE_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic       lim_rst_n,
   output logic       lim_start,
   output logic [9:0] lim_x_pos,
   output logic [9:0] lim_y_pos,
   output logic [9:0] lim_width,
   output logic [9:0] lim_height,
   output logic [1:0] lim_l_r,
   output logic [1:0] lim_u_d,
   input  logic       lim_done,
   input  logic       lim_move_is_valid,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic       pos_update,
   output logic       busy
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ARM    = 3'd1;
   localparam logic [2:0] S_REQ    = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_COMMIT = 3'd4;

   localparam int            TW      = $clog2(DONE_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(DONE_TIMEOUT - 1);

   logic [2:0]    state;
   logic [TW-1:0] to_cnt;
   logic          tick;

   lr_dir_e       lr_raw;
   ud_dir_e       ud_raw;
   lr_dir_e       lr_dec;
   ud_dir_e       ud_dec;
   logic [9:0]    cand_x;
   logic [9:0]    cand_y;
   logic          move_req;

   player_mover_tick_divider #(
      .MOVE_DIV (MOVE_DIV)
   ) u_tick_divider (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Direction decode and candidate formation from the committed position.
   always_comb begin
      lr_raw = LR_NONE;
      ud_raw = UD_NONE;
      if (btn_left ^ btn_right) begin
         lr_raw = btn_right ? LR_RIGHT : LR_LEFT;
      end
      if (btn_up ^ btn_down) begin
         ud_raw = btn_down ? UD_DOWN : UD_UP;
      end

      lr_dec = lr_raw;
`ifdef PLAYER_MOVE_DIAG_EN
      ud_dec = ud_raw;
`else
      // Horizontal motion wins; at most one axis moves per tick.
      ud_dec = (lr_raw != LR_NONE) ? UD_NONE : ud_raw;
`endif

      case (lr_dec)
         LR_RIGHT: cand_x = pos_x + 10'd1;
         LR_LEFT:  cand_x = pos_x - 10'd1;
         default:  cand_x = pos_x;
      endcase
      // Moving up from 0 wraps to 1023 and is then rejected by the bounds check.
      case (ud_dec)
         UD_DOWN: cand_y = pos_y + 10'd1;
         UD_UP:   cand_y = pos_y - 10'd1;
         default: cand_y = pos_y;
      endcase

      move_req = (lr_dec != LR_NONE) || (ud_dec != UD_NONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         to_cnt     <= '0;
         lim_x_pos  <= 10'(START_X);
         lim_y_pos  <= 10'(START_Y);
         lim_l_r    <= LR_NONE;
         lim_u_d    <= UD_NONE;
         pos_x      <= 10'(START_X);
         pos_y      <= 10'(START_Y);
         pos_update <= 1'b0;
      end else begin
         pos_update <= 1'b0;
         case (state)
            S_IDLE: begin
               // Ticks arriving in other states are simply dropped.
               if (tick && move_req) begin
                  lim_x_pos <= cand_x;
                  lim_y_pos <= cand_y;
                  lim_l_r   <= lr_dec;
                  lim_u_d   <= ud_dec;
                  state     <= S_ARM;
               end
            end
            S_ARM: begin
               if (cand_in_field(lim_x_pos, lim_y_pos, FIELD_X0, PLAYER_W, PLAYER_H)) begin
                  state <= S_REQ;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_REQ: begin
               to_cnt <= '0;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               // The position registers load on the way into COMMIT so the
               // new position and the pos_update pulse appear together.
               if (lim_done) begin
                  if (lim_move_is_valid) begin
                     pos_x      <= lim_x_pos;
                     pos_y      <= lim_y_pos;
                     pos_update <= 1'b1;
                  end
                  state <= S_COMMIT;
               end else if (to_cnt == TO_LAST) begin
                  // Limiter never answered: treat as a rejected move.
                  state <= S_COMMIT;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_COMMIT: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Limiter is released only around an active request; dropping lim_rst_n
   // in COMMIT clears its sticky done flag for the next move.
   assign lim_rst_n  = (state == S_REQ) || (state == S_WAIT);
   assign lim_start  = (state == S_REQ);
   assign busy       = (state != S_IDLE);
   assign lim_width  = 10'(PLAYER_W);
   assign lim_height = 10'(PLAYER_H);

endmodule
`default_nettype wire

// File: tb/tb_player_mover.sv
`default_nettype none
// ============================================================================
//  Module      : tb_player_mover
//  Description : Self-checking bench for player_mover. A limiter stand-in
//                answers requests with configurable latency and verdict; a
//                transaction-level reference model predicts every output on
//                every cycle; directed steps pin literal expectations.
//  Option      : PLAYER_MOVE_DIAG_EN selects diagonal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_player_mover;

   localparam int MOVE_DIV     = 4;
   localparam int DONE_TIMEOUT = 15;
   localparam int X_MIN        = 80;
   localparam int X_MAX        = 80 + 480 - 20;
   localparam int Y_MAX        = 480 - 20;
`ifdef PLAYER_MOVE_DIAG_EN
   localparam bit DIAG = 1'b1;
`else
   localparam bit DIAG = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic       lim_rst_n, lim_start, pos_update, busy;
   logic [9:0] lim_x_pos, lim_y_pos, lim_width, lim_height, pos_x, pos_y;
   logic [1:0] lim_l_r, lim_u_d;
   logic       lim_done = 1'b0;
   logic       lim_move_is_valid = 1'b0;

   int  passed = 0;
   int  total  = 0;
   int  n_start = 0;
   int  n_upd   = 0;

   // limiter stand-in configuration
   int  lim_lat_cfg   = 2;     // 0 = never answers
   bit  lim_valid_cfg = 1'b1;
   bit  lim_rand      = 1'b0;
   int  lat_cur = 0;
   int  lcnt    = 0;
   bit  lbusy   = 1'b0;

   always #5 clk = ~clk;

   player_mover #(
      .MOVE_DIV (MOVE_DIV)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .btn_left          (btn_left),
      .btn_right         (btn_right),
      .btn_up            (btn_up),
      .btn_down          (btn_down),
      .lim_rst_n         (lim_rst_n),
      .lim_start         (lim_start),
      .lim_x_pos         (lim_x_pos),
      .lim_y_pos         (lim_y_pos),
      .lim_width         (lim_width),
      .lim_height        (lim_height),
      .lim_l_r           (lim_l_r),
      .lim_u_d           (lim_u_d),
      .lim_done          (lim_done),
      .lim_move_is_valid (lim_move_is_valid),
      .pos_x             (pos_x),
      .pos_y             (pos_y),
      .pos_update        (pos_update),
      .busy              (busy)
   );

   function automatic int pick_lat();
      case ($urandom % 5)
         0:       return 2;
         1:       return 3;
         2:       return 4;
         3:       return 7;
         default: return 0;
      endcase
   endfunction

   // Limiter stand-in: done rises lat clocks after the start pulse, sticky
   // until lim_rst_n drops.
   always @(posedge clk) begin
      if (lim_rst_n !== 1'b1) begin
         lim_done          <= 1'b0;
         lim_move_is_valid <= 1'b0;
         lbusy             <= 1'b0;
         lcnt              <= 0;
      end else if (lim_start === 1'b1) begin
         lbusy             <= 1'b1;
         lcnt              <= 1;
         lat_cur           <= lim_rand ? pick_lat() : lim_lat_cfg;
         lim_move_is_valid <= lim_rand ? 1'($urandom % 2) : lim_valid_cfg;
      end else if (lbusy && !lim_done && lat_cur != 0 && lcnt == lat_cur - 1) begin
         lim_done <= 1'b1;
      end else if (lbusy) begin
         lcnt <= lcnt + 1;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
   endtask

   // ---------------- reference model ----------------
   int  cyc = 0;
   int  mx = 150, my = 90, lx = 150, ly = 90, mlr = 0, mud = 0;
   int  t0 = 0, nwait = 0, done_at = -1;
   bit  act = 1'b0, legal = 1'b0, ok = 1'b0, mvalid = 1'b0;
   bit  e_busy = 1'b0, e_start = 1'b0, e_rstn = 1'b0, e_upd = 1'b0;

   initial begin : model
      int h, v, p, cx, cy;
      bit tick;
      forever begin
         @(posedge clk);
         if (rst) begin
            cyc = 0; mx = 150; my = 90; lx = 150; ly = 90; mlr = 0; mud = 0;
            act = 0; legal = 0; done_at = -1;
            e_busy = 0; e_start = 0; e_rstn = 0; e_upd = 0;
            mvalid = 1;
         end else begin
            tick  = (cyc % MOVE_DIV) == MOVE_DIV - 1;
            e_upd = 0;
            if (!act) begin
               h = (btn_left ^ btn_right) ? (btn_right ? 1 : -1) : 0;
               v = (btn_up ^ btn_down) ? (btn_down ? 1 : -1) : 0;
               if (!DIAG && h != 0) v = 0;
               if (tick && (h != 0 || v != 0)) begin
                  cx = (mx + h) & 1023;
                  cy = (my + v) & 1023;
                  lx = cx; ly = cy;
                  mlr = (h == 1) ? 1 : (h == -1) ? 2 : 0;
                  mud = (v == 1) ? 1 : (v == -1) ? 2 : 0;
                  legal = (cx >= X_MIN) && (cx <= X_MAX) && (cy <= Y_MAX);
                  act = 1; t0 = cyc; nwait = 0; done_at = -1;
               end
            end else begin
               p = cyc - t0;
               if (!legal && p == 1) begin
                  act = 0;
               end else if (legal && p >= 3 && done_at < 0) begin
                  nwait++;
                  if (lim_done) begin
                     ok = lim_move_is_valid; done_at = cyc + 1;
                  end else if (nwait == DONE_TIMEOUT) begin
                     ok = 0; done_at = cyc + 1;
                  end
                  if (done_at >= 0 && ok) begin
                     mx = lx; my = ly; e_upd = 1;
                  end
               end else if (done_at >= 0 && cyc == done_at) begin
                  act = 0;
               end
            end
            cyc++;
            e_busy  = act;
            e_start = act && legal && (cyc == t0 + 2);
            e_rstn  = act && legal && (cyc >= t0 + 2) && (done_at < 0);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin : compare
      forever begin
         @(negedge clk);
         if (lim_start === 1'b1) n_start++;
         if (pos_update === 1'b1) n_upd++;
         if (mvalid) begin
            chk("pos_x",      int'(pos_x),      mx);
            chk("pos_y",      int'(pos_y),      my);
            chk("pos_update", int'(pos_update), int'(e_upd));
            chk("busy",       int'(busy),       int'(e_busy));
            chk("lim_start",  int'(lim_start),  int'(e_start));
            chk("lim_rst_n",  int'(lim_rst_n),  int'(e_rstn));
            chk("lim_x_pos",  int'(lim_x_pos),  lx);
            chk("lim_y_pos",  int'(lim_y_pos),  ly);
            chk("lim_l_r",    int'(lim_l_r),    mlr);
            chk("lim_u_d",    int'(lim_u_d),    mud);
            chk("lim_width",  int'(lim_width),  20);
            chk("lim_height", int'(lim_height), 20);
         end
      end
   end

   task automatic wait_upd(input int maxc, output bit got);
      got = 0;
      for (int i = 0; i < maxc && !got; i++) begin
         @(negedge clk);
         if (pos_update === 1'b1) got = 1;
      end
   endtask

   task automatic set_btn(input bit l, input bit r, input bit u, input bit d);
      btn_left = l; btn_right = r; btn_up = u; btn_down = d;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin : stim
      bit got;
      bit seen;
      int s0, u0;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_pos_x", int'(pos_x), 150);
      chk("rst_pos_y", int'(pos_y), 90);
      chk("rst_rstn",  int'(lim_rst_n), 0);
      chk("rst_busy",  int'(busy), 0);

      // right held, 2-clock limiter accepting: first tick is cycle 3
      set_btn(0, 1, 0, 0);
      rst = 1'b0;
      wait_upd(30, got);
      chk("first_upd_seen",  int'(got), 1);
      chk("first_upd_cycle", cyc, 8);
      chk("first_upd_x",     int'(pos_x), 151);
      chk("first_upd_y",     int'(pos_y), 90);
      set_btn(0, 0, 0, 0);
      repeat (8) @(negedge clk);

      // left+right cancel
      s0 = n_start; seen = 0;
      set_btn(1, 1, 0, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy === 1'b1) seen = 1;
      end
      chk("lr_starts", n_start - s0, 0);
      chk("lr_busy",   int'(seen), 0);
      chk("lr_pos_x",  int'(pos_x), 151);

      // walk to the left edge, then push against it
      set_btn(1, 0, 0, 0);
      for (int i = 0; i < 1200 && pos_x !== 10'd80; i++) @(negedge clk);
      s0 = n_start;
      repeat (40) @(negedge clk);
      chk("left_edge_starts", n_start - s0, 0);
      chk("left_edge_x",      int'(pos_x), 80);

      // walk to the top, wrap to 1023 rejected
      set_btn(0, 0, 1, 0);
      for (int i = 0; i < 1200 && pos_y !== 10'd0; i++) @(negedge clk);
      s0 = n_start;
      repeat (40) @(negedge clk);
      chk("top_edge_starts", n_start - s0, 0);
      chk("top_edge_y",      int'(pos_y), 0);
      chk("top_wrap_cand",   int'(lim_y_pos), 1023);
      set_btn(0, 0, 0, 0);
      repeat (8) @(negedge clk);

      // one down tick rejected by the limiter
      lim_valid_cfg = 1'b0;
      s0 = n_start; u0 = n_upd;
      set_btn(0, 0, 0, 1);
      repeat (4) @(negedge clk);
      set_btn(0, 0, 0, 0);
      repeat (30) @(negedge clk);
      chk("rej_starts", n_start - s0, 1);
      chk("rej_upds",   n_upd - u0, 0);
      chk("rej_y",      int'(pos_y), 0);
      chk("rej_rstn",   int'(lim_rst_n), 0);

      // limiter never answers: timeout, then a normal move still works
      lim_valid_cfg = 1'b1;
      lim_lat_cfg   = 0;
      s0 = n_start; u0 = n_upd;
      set_btn(0, 1, 0, 0);
      repeat (4) @(negedge clk);
      set_btn(0, 0, 0, 0);
      repeat (30) @(negedge clk);
      chk("to_starts", n_start - s0, 1);
      chk("to_upds",   n_upd - u0, 0);
      chk("to_x",      int'(pos_x), 80);
      chk("to_busy",   int'(busy), 0);
      lim_lat_cfg = 2;
      set_btn(0, 1, 0, 0);
      repeat (4) @(negedge clk);
      set_btn(0, 0, 0, 0);
      repeat (12) @(negedge clk);
      chk("after_to_x", int'(pos_x), 81);

      // right+down from reset
      set_btn(0, 1, 0, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_upd(30, got);
      chk("diag_upd_seen",  int'(got), 1);
      chk("diag_upd_cycle", cyc, 8);
      chk("diag_x",   int'(pos_x), 151);
      chk("diag_y",   int'(pos_y), DIAG ? 91 : 90);
      chk("diag_l_r", int'(lim_l_r), 1);
      chk("diag_u_d", int'(lim_u_d), DIAG ? 1 : 0);

      // reset in the middle of WAIT
      lim_lat_cfg = 0;
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (lim_rst_n === 1'b1) got = 1;
      end
      chk("wait_reached", int'(got), 1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_x",    int'(pos_x), 150);
      chk("midrst_y",    int'(pos_y), 90);
      chk("midrst_rstn", int'(lim_rst_n), 0);
      chk("midrst_busy", int'(busy), 0);
      rst = 1'b0;
      set_btn(0, 0, 0, 0);
      lim_lat_cfg = 2;

      // randomized traffic
      lim_rand = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom % 3 == 0) begin
            {btn_left, btn_right, btn_up, btn_down} = 4'($urandom);
         end
         rst = ($urandom % 700 == 0);
      end
      rst = 1'b0;
      set_btn(0, 0, 0, 0);
      repeat (30) @(negedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog t=%0t actual=running required=finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
